// File: rtl/morse_receiver_pkg.sv
// Shared Morse timing constants and receiver FSM state encoding.
// Imported by the receiver top and its run-length counter.
package morse_receiver_pkg;

    // Mark/space lengths, in ticks, shared with the transmit path
    localparam int DOT_TICKS  = 1;
    localparam int DASH_TICKS = 3;
    localparam int LETTER_GAP = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

endpackage

// File: rtl/morse_receiver_if.sv
// Receiver line/letter bundle.
// master: drives tick/line_in, sees letters; slave: the receiver itself.
interface morse_receiver_if #(
    parameter int MAX_SYM = 4
);
    logic               tick;
    logic               line_in;
    logic [MAX_SYM-1:0] letter_code;
    logic [2:0]         letter_len;
    logic               letter_valid;
    logic               letter_error;

    modport master (
        output tick, line_in,
        input  letter_code, letter_len, letter_valid, letter_error
    );

    modport slave (
        input  tick, line_in,
        output letter_code, letter_len, letter_valid, letter_error
    );
endinterface

// File: rtl/morse_run_counter.sv
// Saturating run-length counter, advanced only on tick.
// Ports: clock, clear, tick, restart (load 1), count.
module morse_run_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             tick,
    input  logic             restart,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (tick) begin
            // Restart loads 1: the current sample is the first of a new run
            if (restart)
                count <= CNT_W'(1);
            else if (count != CNT_MAX)
                count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: classifies mark/space runs into dots/dashes, emits letters.
// Ports: clock, clear (sync, active-high), bus (slave: tick/line_in in, letter out).
module morse_receiver
    import morse_receiver_pkg::*;
#(
    parameter int MAX_SYM = 4,
    parameter int CNT_W   = 3
) (
    input logic            clock,
    input logic            clear,
    morse_receiver_if.slave bus
);
    state_t             state, state_n;
    logic [MAX_SYM-1:0] sbuf, sbuf_n;
    logic [2:0]         nsym, nsym_n;
    logic               bad, bad_n;
    logic               restart;
    logic               sym;
    logic               emit_ok, emit_err;
    logic [CNT_W-1:0]   run;

    morse_run_counter #(.CNT_W(CNT_W)) u_run (
        .clock   (clock),
        .clear   (clear),
        .tick    (bus.tick),
        .restart (restart),
        .count   (run)
    );

    always_comb begin
        state_n  = state;
        sbuf_n   = sbuf;
        nsym_n   = nsym;
        bad_n    = bad;
        restart  = 1'b0;
        sym      = 1'b0;
        emit_ok  = 1'b0;
        emit_err = 1'b0;
        if (bus.tick) begin
            unique case (state)
                IDLE: begin
                    restart = 1'b1;
                    if (bus.line_in) begin
                        state_n = MARK;
                        sbuf_n  = '0;
                        nsym_n  = '0;
                        bad_n   = 1'b0;
                    end
                end
                MARK: begin
                    if (!bus.line_in) begin
                        restart = 1'b1;
                        state_n = SPACE;
                        sym     = (run == CNT_W'(DASH_TICKS));
                        // Saturated long marks never match a legal length
                        if (run != CNT_W'(DOT_TICKS) &&
                            run != CNT_W'(DASH_TICKS))
                            bad_n = 1'b1;
                        if (nsym == 3'(MAX_SYM)) begin
                            bad_n = 1'b1;
                        end else begin
                            sbuf_n = {sbuf[MAX_SYM-2:0], sym};
                            nsym_n = nsym + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    if (bus.line_in) begin
                        restart = 1'b1;
                        state_n = MARK;
                        // A 2-tick space is neither symbol nor letter gap
                        if (run != CNT_W'(1))
                            bad_n = 1'b1;
                    end else if (run == CNT_W'(LETTER_GAP - 1)) begin
                        state_n  = IDLE;
                        emit_ok  = !bad;
                        emit_err = bad;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state            <= IDLE;
            sbuf             <= '0;
            nsym             <= '0;
            bad              <= 1'b0;
            bus.letter_code  <= '0;
            bus.letter_len   <= '0;
            bus.letter_valid <= 1'b0;
            bus.letter_error <= 1'b0;
        end else begin
            state            <= state_n;
            sbuf             <= sbuf_n;
            nsym             <= nsym_n;
            bad              <= bad_n;
            bus.letter_valid <= emit_ok;
            bus.letter_error <= emit_err;
            if (emit_ok) begin
                bus.letter_code <= sbuf;
                bus.letter_len  <= nsym;
            end
        end
    end
endmodule
